// File: rtl/capture_ram.sv
// capture_ram: triggered fixed-length capture of a signed sample stream into an
// on-chip buffer, with a registered random-access read port. Optional peak tracking
// is enabled by defining CAPTURE_PEAK_EN.
module capture_ram #(
  parameter int NBIT  = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic signed [NBIT-1:0] din,
  output logic                   busy,
  output logic                   done,
  output logic [AW:0]            count,
`ifdef CAPTURE_PEAK_EN
  output logic signed [NBIT-1:0] peak_max,
  output logic signed [NBIT-1:0] peak_min,
`endif
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic [NBIT-1:0]        rd_data,
  output logic                   rd_valid
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam logic [AW:0] LAST_COUNT = (AW+1)'(DEPTH - 1);

  logic [1:0]      state_q, state_d;
  logic            start_q;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW:0]     count_q, count_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [NBIT-1:0] rd_data_q;
  logic            rd_valid_q;
  logic            start_edge_s;
  logic            accept_s;
  logic            we_s;
  logic [NBIT-1:0] mem_q [DEPTH];

  assign start_edge_s = start & ~start_q;
  // A trigger is only honoured outside CAPTURE; a capture never restarts mid-run.
  assign accept_s     = start_edge_s & (state_q != CAPTURE);

  // Next-state, write-enable and pointer/count update.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    we_s    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          state_d = CAPTURE;
          wptr_d  = {AW{1'b0}};
          count_d = {(AW+1){1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          we_s    = 1'b1;
          wptr_d  = wptr_q + AW'(1'b1);
          count_d = count_q + (AW+1)'(1'b1);
          if (count_q == LAST_COUNT) begin
            state_d = DONE;
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == CAPTURE);
    done_d = (state_d == DONE);
  end

  // Control state and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      wptr_q  <= {AW{1'b0}};
      count_q <= {(AW+1){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Sample buffer write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[wptr_q] <= din;
    end
  end

  // Registered read port; same-address collisions see the pre-write word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= {NBIT{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= mem_q[rd_addr];
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

`ifdef CAPTURE_PEAK_EN
  localparam logic signed [NBIT-1:0] S_MIN = {1'b1, {(NBIT-1){1'b0}}};
  localparam logic signed [NBIT-1:0] S_MAX = {1'b0, {(NBIT-1){1'b1}}};

  logic signed [NBIT-1:0] peak_max_q, peak_max_d;
  logic signed [NBIT-1:0] peak_min_q, peak_min_d;

  // Peak trackers seed to the opposite extremes so the first sample always wins.
  always_comb begin
    peak_max_d = peak_max_q;
    peak_min_d = peak_min_q;
    if (accept_s) begin
      peak_max_d = S_MIN;
      peak_min_d = S_MAX;
    end else if (we_s) begin
      if (din > peak_max_q) begin
        peak_max_d = din;
      end else begin
        peak_max_d = peak_max_q;
      end
      if (din < peak_min_q) begin
        peak_min_d = din;
      end else begin
        peak_min_d = peak_min_q;
      end
    end else begin
      peak_max_d = peak_max_q;
      peak_min_d = peak_min_q;
    end
  end

  // Peak registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_max_q <= {NBIT{1'b0}};
      peak_min_q <= {NBIT{1'b0}};
    end else begin
      peak_max_q <= peak_max_d;
      peak_min_q <= peak_min_d;
    end
  end

  assign peak_max = peak_max_q;
  assign peak_min = peak_min_q;
`endif

endmodule

// File: tb/tb_capture_ram.sv
// Scoreboard bench for capture_ram with DEPTH=16: reads push expected words,
// a negedge monitor pops and compares whenever rd_valid is presented.
module tb_capture_ram;
  localparam int NBIT  = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic                   abort;
  logic signed [NBIT-1:0] din;
  logic                   busy;
  logic                   done;
  logic [AW:0]            count;
  logic                   rd_en;
  logic [AW-1:0]          rd_addr;
  logic [NBIT-1:0]        rd_data;
  logic                   rd_valid;
`ifdef CAPTURE_PEAK_EN
  logic signed [NBIT-1:0] peak_max;
  logic signed [NBIT-1:0] peak_min;
`endif

  int checks   = 0;
  int failures = 0;
  int busy_cyc;
  logic [NBIT-1:0] exp_q [$];

  capture_ram #(.NBIT(NBIT), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .din      (din),
    .busy     (busy),
    .done     (done),
    .count    (count),
`ifdef CAPTURE_PEAK_EN
    .peak_max (peak_max),
    .peak_min (peak_min),
`endif
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one read at the current negedge and queue its expected word.
  task automatic rd(input int addr, input logic [NBIT-1:0] exp);
    rd_en   = 1'b1;
    rd_addr = AW'(addr);
    exp_q.push_back(exp);
    @(negedge clk);
  endtask

  // Monitor: compare every presented read word against the scoreboard head.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: got %0h expected no rd_valid", rd_data);
      end else begin
        logic [NBIT-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          failures++;
          $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; rd_en = 1'b0; rd_addr = '0; din = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
`ifdef CAPTURE_PEAK_EN
    chk("rst_peak_max", {16'd0, peak_max}, 32'd0);
    chk("rst_peak_min", {16'd0, peak_min}, 32'd0);
`endif
    repeat (10) @(negedge clk);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Full capture of the -8..7 ramp.
    start = 1'b1;
    busy_cyc = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      din = 16'(i - 8);
      if (i == 0) start = 1'b0;
    end
    @(negedge clk);
    chk("full_busy_cycles", 32'(busy_cyc), 32'd16);
    chk("full_busy_end", 32'(busy), 32'd0);
    chk("full_done", 32'(done), 32'd1);
    chk("full_count", 32'(count), 32'd16);
    for (int a = 0; a < 16; a++) rd(a, 16'(a - 8));
    rd_en = 1'b0;
    @(negedge clk);
    chk("rd_valid_drop", 32'(rd_valid), 32'd0);
    chk("rd_data_hold", 32'(rd_data), 32'd7);

    // Abort after five writes.
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      din = 16'(50 + i);
      if (i == 0) start = 1'b0;
    end
    @(negedge clk);
    abort = 1'b1;
    din = 16'd99;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_count", 32'(count), 32'd5);
    for (int a = 0; a < 5; a++) rd(a, 16'(50 + a));
    rd(5, 16'hFFFD);
    rd_en = 1'b0;

    // start held high for 40 cycles gives exactly one capture.
    start = 1'b1;
    busy_cyc = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      din = 16'(200 + j);
      if (busy) busy_cyc++;
    end
    chk("held_busy_cycles", 32'(busy_cyc), 32'd16);
    chk("held_done", 32'(done), 32'd1);
    chk("held_count", 32'(count), 32'd16);

    // Re-trigger, collide read/write at addr 3, then async reset mid-capture.
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("retrig_busy", 32'(busy), 32'd1);
        chk("retrig_count", 32'(count), 32'd0);
      end
      din = 16'(300 + i);
      if (i == 3) begin
        rd_en = 1'b1;
        rd_addr = 4'd3;
        exp_q.push_back(16'd203);
      end else begin
        rd_en = 1'b0;
      end
    end
    @(negedge clk);
    chk("pre_rst_count", 32'(count), 32'd6);
    rst = 1'b1;
    start = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    rd(3, 16'd303);
    rd(0, 16'd300);
    rd(6, 16'd206);
    rd_en = 1'b0;

`ifdef CAPTURE_PEAK_EN
    start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      din = (i == 0) ? 16'sd3 : (i == 1) ? -16'sd20 : (i == 2) ? 16'sd7 : 16'sd0;
      if (i == 0) start = 1'b0;
    end
    @(negedge clk);
    chk("peak_done", 32'(done), 32'd1);
    chk("peak_max", {16'd0, peak_max}, 32'd7);
    chk("peak_min", {16'd0, peak_min}, 32'h0000FFEC);
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/capture_ram.md
# capture_ram

Sample sink that records the processed signed sample stream (e.g. differentiator or filter output) into an on-chip buffer. A rising edge on `start` triggers a fixed-length capture, and `done` is raised when the buffer is full. The block sits at the tail of the processing chain, opposite the sample ROM source. Captured data is read back through a random-access port for inspection or later stages.

## Interface
Parameters:
- NBIT, 16, sample width in bits (two's complement)
- DEPTH, 1024, samples per capture; power of two, at least 4
- AW, 10, address width; must equal log2(DEPTH)

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  capture trigger; a capture begins on the 0→1 edge only
- abort  in  1  terminates an active capture at the next edge
- din  in  NBIT  signed sample; one sample is accepted per clock while capturing
- busy  out  1  high while in CAPTURE
- done  out  1  high while in DONE
- count  out  AW+1  number of samples written by the current or last capture
- rd_en  in  1  read request
- rd_addr  in  AW  read address
- rd_data  out  NBIT  read data, registered
- rd_valid  out  1  high for one cycle when rd_data holds the requested word

## Operation
- FSM states: IDLE, CAPTURE, DONE.
- Reset values: state=IDLE; busy, done, rd_valid and the internal start_q all 0; count=0; rd_data=0. Buffer contents are not cleared.
- Trigger edge: `start_edge = start & ~start_q`, where start_q is start registered every cycle.
- IDLE→CAPTURE on start_edge. On that edge, count←0 and the write pointer←0.
- DONE→CAPTURE on start_edge, with the same clearing.
- In CAPTURE, every edge writes din to mem[wptr] and increments both wptr and count.
- CAPTURE→DONE on the edge that performs write number DEPTH, at which point count=DEPTH.
- In CAPTURE with abort=1: go to IDLE, perform no write on that edge, and keep count at its current value.
- abort has priority over start_edge and over the final write.
- abort in IDLE or DONE is ignored.
- start_edge during CAPTURE is ignored. Capture never restarts mid-run.
- Reads: when rd_en=1 at an edge, rd_data←mem[rd_addr] and rd_valid←1. Otherwise rd_valid←0 and rd_data holds its value.
- Reads are legal in every state.
- If a read and a write hit the same address on the same edge, the read returns the old contents (read-before-write).
- Reads at addresses ≥ count return stale contents. This is not an error.
- Arithmetic: wptr wraps only at DEPTH, and wrap never occurs in use. count saturates at DEPTH by construction.
- If rst asserts mid-capture, the state is forced to IDLE asynchronously and count clears to 0.

## Timing
- Trigger: start rises before edge N, so edge N sees start_edge and enters CAPTURE. The first sample is written at edge N+1, and busy=1 from after edge N.
- Capture length: DEPTH consecutive edges, N+1 through N+DEPTH.
- done=1 and busy=0 from after edge N+DEPTH.
- Throughput: one sample per clock with no gaps. din must be stable around every rising edge while busy=1.
- Read latency: 1 cycle. rd_en at edge K makes rd_data and rd_valid valid after edge K.
- Back-to-back reads are supported at one word per clock.
- start held high continuously produces exactly one capture. A re-trigger requires start to go low for at least one edge.

## Configuration
- CAPTURE_PEAK_EN defined: adds outputs `peak_max` and `peak_min` (out, NBIT, signed).
  - On start_edge, peak_max resets to the most negative value (−2^(NBIT−1)) and peak_min to the most positive value (2^(NBIT−1)−1).
  - Each written sample updates them with a signed compare.
  - Values are valid once done=1, and hold through DONE and IDLE until the next start_edge.
  - Reset value of both is 0.
- CAPTURE_PEAK_EN undefined: the ports and logic are absent, and all other behaviour is identical.

## Test plan
- Reset then idle: rst high for 2 cycles, then released → busy=0, done=0, count=0, rd_valid=0. start held low for 10 cycles → count stays 0.
- Full capture (DEPTH=16): pulse start, drive din=−8…7 ramp → busy for exactly 16 cycles, then done=1 and count=16. Reads of addr 0..15 return −8..7 with rd_valid one cycle after each rd_en.
- Abort: start a capture, assert abort after 5 writes → IDLE with count=5, done=0. mem[0..4] hold the first 5 samples and mem[5] is unchanged.
- Start held and re-trigger: keep start high for 40 cycles → exactly one capture (done at +16, no restart). Drop start then raise it again → a new capture, count restarts at 0.
- Read/write collision and async reset: read addr 3 on the edge that writes addr 3 → the old value is returned. Assert rst mid-capture → busy=0 and count=0 immediately, without waiting for a clock.
- Peak (CAPTURE_PEAK_EN): samples {3, −20, 7, 0, …, 0} → peak_max=7, peak_min=−20 at done.
